ahb_response_mux: RTL and testbench
===================================

# ahb_response_mux

AHB-Lite subordinate-to-manager response multiplexer with built-in default subordinate, downstream of the address decoder in the interconnect. Registers the decoder's one-hot select during the address phase and, during the data phase, routes the addressed subordinate's HRDATA/HREADYOUT/HRESP to the manager. Answers decoder HSELd selections with the protocol two-cycle ERROR response. Its HREADY output is the bus-wide HREADY, fed back to the decoder and all subordinates.

## Interface
- DATA_WIDTH, 32, width of all read-data buses
- TIMEOUT_CYCLES, 16, wait-state limit before forced ERROR; used only with AHB_MUX_TIMEOUT_EN
- HCLK  in  1  bus clock, all state on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL1, HSEL2, HSEL3, HSELd  in  1 each  decoder selects, address phase
- HTRANS  in  2  manager transfer type, address phase
- HRDATA1, HRDATA2, HRDATA3  in  DATA_WIDTH  subordinate read data
- HREADYOUT1, HREADYOUT2, HREADYOUT3  in  1  subordinate ready
- HRESP1, HRESP2, HRESP3  in  1  subordinate response, 0 OKAY / 1 ERROR
- HRDATA  out  DATA_WIDTH  muxed read data to manager
- HREADY  out  1  muxed ready to manager, decoder, subordinates
- HRESP  out  1  muxed response to manager

## Operation
- Data-phase select register sel_q, 3 bits: NONE, S1, S2, S3, DEF. Reset value NONE.
- When HREADY=1 at a rising edge, sel_q loads from the selects. Priority when several are high: HSEL1 > HSEL2 > HSEL3 > HSELd. All low loads NONE. When HREADY=0, sel_q holds.
- Output mux, combinational from sel_q:
  - S1/S2/S3: HRDATA=HRDATAn, HREADY=HREADYOUTn, HRESP=HRESPn.
  - NONE: HRDATA=0, HREADY=1, HRESP=0.
  - DEF: HRDATA=0, HREADY and HRESP come from the default FSM.
- Default FSM states are D_IDLE, D_ERR1 and D_ERR2. Reset state is D_IDLE.
  - D_IDLE outputs HREADY=1, HRESP=0. It moves to D_ERR1 when HREADY=1, HSELd=1 (and no higher-priority select), and HTRANS[1]=1 (NONSEQ/SEQ).
  - D_ERR1 outputs HREADY=0, HRESP=1. It always moves to D_ERR2.
  - D_ERR2 outputs HREADY=1, HRESP=1. It moves to D_ERR1 if the D_IDLE entry condition holds, else to D_IDLE.
  - IDLE/BUSY to HSELd gives a zero-wait OKAY.
- Outputs after reset: HRDATA=0, HREADY=1, HRESP=0.

## Timing
- Address phase in cycle N with HREADY=1 means the data phase runs from cycle N+1, using sel_q.
- Mux path from subordinate inputs to outputs is purely combinational: zero latency.
- The default ERROR always takes exactly 2 data-phase cycles: HREADY 0 then 1, with HRESP=1 in both.
- Back-to-back HSELd transfers: every D_ERR2 chains straight to D_ERR1, with no D_IDLE cycle in between.
- A subordinate wait state (HREADYOUTn=0) holds sel_q and therefore freezes the decoder selection. The manager must hold the address, per protocol.
- HRESET asserted mid-transfer:
  - outputs go immediately to reset values;
  - sel_q goes to NONE and the FSM to D_IDLE;
  - the in-flight response is abandoned.

## Configuration
- Macro AHB_MUX_TIMEOUT_EN.
- Defined: the block adds a wait-state counter (width clog2(TIMEOUT_CYCLES+1)), reset to 0.
  - It increments each cycle that sel_q is S1/S2/S3 and HREADYOUTn=0.
  - It clears whenever HREADY=1.
  - When the count reaches TIMEOUT_CYCLES, the block overrides the mux: one cycle of HREADY=0/HRESP=1, then one cycle of HREADY=1/HRESP=1. It ignores the subordinate during these 2 cycles and clears the counter.
  - sel_q updates at the HREADY=1 edge as normal.
- Undefined: no counter is present. Subordinate wait states are passed through unbounded, and TIMEOUT_CYCLES is unused.

## Test plan
- Reset: assert HRESET mid-transfer, then release → HREADY=1, HRESP=0, HRDATA=0 immediately; next transfer decodes normally.
- Read S2:
  - stimulus: HSEL2=1, HTRANS=NONSEQ, HREADYOUT2 low for 2 cycles, HRDATA2=0xA5A5_0002;
  - response: HREADY low 2 cycles, then high with HRDATA=0xA5A5_0002, HRESP=0; sel_q holds S2 throughout.
- Default subordinate: HSELd=1, HTRANS=NONSEQ, twice back-to-back → HREADY/HRESP sequence 0/1, 1/1, 0/1, 1/1, then 1/0 idle.
- Default subordinate with HTRANS=IDLE → single cycle HREADY=1, HRESP=0; FSM stays D_IDLE.
- Priority and NONE:
  - HSEL1 and HSEL3 both high, HRDATA1=0x1 → output 0x1;
  - all selects low → HREADY=1, HRESP=0, HRDATA=0.
- Timeout, with AHB_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=4:
  - stimulus: S1 holds HREADYOUT1=0 indefinitely;
  - response: HREADY low for 4 cycles, then 0/1 and 1/1 ERROR pair, then the next address phase is accepted.
  - Without the macro, HREADY stays low indefinitely.

Source files
------------

// File: rtl/ahb_response_mux.sv
// rtl/ahb_response_mux.sv - AHB-Lite response mux with built-in default subordinate (optional AHB_MUX_TIMEOUT_EN)
module ahb_response_mux #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL1,
    input  logic                  HSEL2,
    input  logic                  HSEL3,
    input  logic                  HSELd,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HRDATA1,
    input  logic [DATA_WIDTH-1:0] HRDATA2,
    input  logic [DATA_WIDTH-1:0] HRDATA3,
    input  logic                  HREADYOUT1,
    input  logic                  HREADYOUT2,
    input  logic                  HREADYOUT3,
    input  logic                  HRESP1,
    input  logic                  HRESP2,
    input  logic                  HRESP3,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic                  HRESP
);

    // Data-phase selection encodings
    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_S1   = 3'd1;
    localparam logic [2:0] SEL_S2   = 3'd2;
    localparam logic [2:0] SEL_S3   = 3'd3;
    localparam logic [2:0] SEL_DEF  = 3'd4;

    // Default subordinate states
    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_ERR1 = 2'd1;
    localparam logic [1:0] D_ERR2 = 2'd2;

    logic [2:0]            sel_q;
    logic [2:0]            sel_d;
    logic [1:0]            d_state;
    logic [1:0]            d_next;
    logic                  def_start;
    logic                  def_ready;
    logic                  def_resp;
    logic                  sub_sel;
    logic [DATA_WIDTH-1:0] sub_data;
    logic                  sub_ready;
    logic                  sub_resp;
    logic [DATA_WIDTH-1:0] mux_data;
    logic                  mux_ready;
    logic                  mux_resp;

    // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY
    logic unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // Fixed-priority encode of the decoder selects: HSEL1 > HSEL2 > HSEL3 > HSELd
    always_comb begin
        sel_d = SEL_NONE;
        if (HSEL1)
            sel_d = SEL_S1;
        else if (HSEL2)
            sel_d = SEL_S2;
        else if (HSEL3)
            sel_d = SEL_S3;
        else if (HSELd)
            sel_d = SEL_DEF;
    end

    // An active transfer accepted for the default subordinate starts an ERROR pair
    assign def_start = HREADY && (sel_d == SEL_DEF) && HTRANS[1];

    // Capture the address-phase selection; a stalled data phase freezes it
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            sel_q <= SEL_NONE;
        else if (HREADY)
            sel_q <= sel_d;
    end

    // Default subordinate next-state: ERR1 -> ERR2, and ERR2 chains straight into ERR1
    always_comb begin
        d_next = D_IDLE;
        case (d_state)
            D_IDLE:  d_next = def_start ? D_ERR1 : D_IDLE;
            D_ERR1:  d_next = D_ERR2;
            D_ERR2:  d_next = def_start ? D_ERR1 : D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    // Default subordinate state register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            d_state <= D_IDLE;
        else
            d_state <= d_next;
    end

    // Default subordinate response: two-cycle ERROR, otherwise zero-wait OKAY
    always_comb begin
        def_ready = 1'b1;
        def_resp  = 1'b0;
        case (d_state)
            D_ERR1: begin
                def_ready = 1'b0;
                def_resp  = 1'b1;
            end
            D_ERR2: begin
                def_ready = 1'b1;
                def_resp  = 1'b1;
            end
            default: begin
                def_ready = 1'b1;
                def_resp  = 1'b0;
            end
        endcase
    end

    // Route the addressed real subordinate; non-subordinate selections idle at OKAY
    always_comb begin
        sub_sel   = 1'b1;
        sub_data  = '0;
        sub_ready = 1'b1;
        sub_resp  = 1'b0;
        case (sel_q)
            SEL_S1: begin
                sub_data  = HRDATA1;
                sub_ready = HREADYOUT1;
                sub_resp  = HRESP1;
            end
            SEL_S2: begin
                sub_data  = HRDATA2;
                sub_ready = HREADYOUT2;
                sub_resp  = HRESP2;
            end
            SEL_S3: begin
                sub_data  = HRDATA3;
                sub_ready = HREADYOUT3;
                sub_resp  = HRESP3;
            end
            default: sub_sel = 1'b0;
        endcase
    end

    // Combine subordinate, default subordinate and the empty (NONE) data phase
    always_comb begin
        mux_data  = '0;
        mux_ready = 1'b1;
        mux_resp  = 1'b0;
        if (sub_sel) begin
            mux_data  = sub_data;
            mux_ready = sub_ready;
            mux_resp  = sub_resp;
        end else if (sel_q == SEL_DEF) begin
            mux_ready = def_ready;
            mux_resp  = def_resp;
        end
    end

`ifdef AHB_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             to_err1;
    logic             to_err2;

    // Limit reached: first half of the forced ERROR pair
    assign to_err1 = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Count consecutive subordinate wait states; the forced ERROR pair follows the limit
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wait_cnt <= '0;
            to_err2  <= 1'b0;
        end else begin
            to_err2 <= to_err1;
            if (to_err1 || HREADY)
                wait_cnt <= '0;
            else if (sub_sel && !sub_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Forced ERROR overrides the subordinate for its two cycles
    always_comb begin
        HRDATA = mux_data;
        HREADY = mux_ready;
        HRESP  = mux_resp;
        if (to_err1) begin
            HRDATA = '0;
            HREADY = 1'b0;
            HRESP  = 1'b1;
        end else if (to_err2) begin
            HRDATA = '0;
            HREADY = 1'b1;
            HRESP  = 1'b1;
        end
    end
`else
    // No wait-state limit in this build
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;

    // Outputs come straight from the mux
    always_comb begin
        HRDATA = mux_data;
        HREADY = mux_ready;
        HRESP  = mux_resp;
    end
`endif

endmodule

// File: tb/tb_ahb_response_mux.sv
// tb/tb_ahb_response_mux.sv - directed table-driven bench for ahb_response_mux
module tb_ahb_response_mux;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL1, HSEL2, HSEL3, HSELd;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA1, HRDATA2, HRDATA3;
    logic        HREADYOUT1, HREADYOUT2, HREADYOUT3;
    logic        HRESP1, HRESP2, HRESP3;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int passed = 0;
    int total  = 0;

    ahb_response_mux #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL1      (HSEL1),
        .HSEL2      (HSEL2),
        .HSEL3      (HSEL3),
        .HSELd      (HSELd),
        .HTRANS     (HTRANS),
        .HRDATA1    (HRDATA1),
        .HRDATA2    (HRDATA2),
        .HRDATA3    (HRDATA3),
        .HREADYOUT1 (HREADYOUT1),
        .HREADYOUT2 (HREADYOUT2),
        .HREADYOUT3 (HREADYOUT3),
        .HRESP1     (HRESP1),
        .HRESP2     (HRESP2),
        .HRESP3     (HRESP3),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [3:0]  sel;   // {HSELd, HSEL3, HSEL2, HSEL1}
        logic [1:0]  trans;
        logic [31:0] d1, d2, d3;
        logic [2:0]  rdy;   // {HREADYOUT3, HREADYOUT2, HREADYOUT1}
        logic [2:0]  rsp;   // {HRESP3, HRESP2, HRESP1}
        logic [31:0] e_data;
        logic        e_ready;
        logic        e_resp;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic [3:0] sel, logic [1:0] trans, logic [31:0] d1,
                                logic [31:0] d2, logic [31:0] d3, logic [2:0] rdy,
                                logic [2:0] rsp, logic [31:0] e_data, logic e_ready,
                                logic e_resp);
        vec_t v;
        v.sel = sel; v.trans = trans; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.rdy = rdy; v.rsp = rsp; v.e_data = e_data; v.e_ready = e_ready; v.e_resp = e_resp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        {HSELd, HSEL3, HSEL2, HSEL1}          = v.sel;
        HTRANS                                = v.trans;
        HRDATA1 = v.d1; HRDATA2 = v.d2; HRDATA3 = v.d3;
        {HREADYOUT3, HREADYOUT2, HREADYOUT1} = v.rdy;
        {HRESP3, HRESP2, HRESP1}             = v.rsp;
    endtask

    task automatic idle_inputs();
        {HSELd, HSEL3, HSEL2, HSEL1} = 4'b0000;
        HTRANS = T_IDLE;
        HRDATA1 = 32'h0; HRDATA2 = 32'h0; HRDATA3 = 32'h0;
        {HREADYOUT3, HREADYOUT2, HREADYOUT1} = 3'b111;
        {HRESP3, HRESP2, HRESP1} = 3'b000;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [31:0] e_data,
                           input logic e_ready, input logic e_resp);
        chk({name, ".hrdata"}, HRDATA, e_data);
        chk({name, ".hready"}, {31'b0, HREADY}, {31'b0, e_ready});
        chk({name, ".hresp"},  {31'b0, HRESP},  {31'b0, e_resp});
    endtask

    initial begin
        vecs[0]  = mk(4'b0000, T_IDLE,   32'h1, 32'hA5A5_0002, 32'h33, 3'b111, 3'b000, 32'h0,          1'b1, 1'b0);
        vecs[1]  = mk(4'b0010, T_NONSEQ, 32'h1, 32'hA5A5_0002, 32'h33, 3'b101, 3'b000, 32'h0,          1'b1, 1'b0);
        vecs[2]  = mk(4'b0000, T_IDLE,   32'h1, 32'hA5A5_0002, 32'h33, 3'b101, 3'b000, 32'hA5A5_0002,  1'b0, 1'b0);
        vecs[3]  = mk(4'b0001, T_NONSEQ, 32'h1, 32'hA5A5_0002, 32'h33, 3'b101, 3'b000, 32'hA5A5_0002,  1'b0, 1'b0);
        vecs[4]  = mk(4'b0101, T_NONSEQ, 32'h1, 32'hA5A5_0002, 32'h33, 3'b111, 3'b000, 32'hA5A5_0002,  1'b1, 1'b0);
        vecs[5]  = mk(4'b0100, T_NONSEQ, 32'h1, 32'hA5A5_0002, 32'h33, 3'b111, 3'b000, 32'h1,          1'b1, 1'b0);
        vecs[6]  = mk(4'b1000, T_NONSEQ, 32'h1, 32'hA5A5_0002, 32'h33, 3'b111, 3'b100, 32'h33,         1'b1, 1'b1);
        vecs[7]  = mk(4'b1000, T_NONSEQ, 32'h1, 32'hA5A5_0002, 32'h33, 3'b111, 3'b000, 32'h0,          1'b0, 1'b1);
        vecs[8]  = mk(4'b1000, T_NONSEQ, 32'h1, 32'hA5A5_0002, 32'h33, 3'b111, 3'b000, 32'h0,          1'b1, 1'b1);
        vecs[9]  = mk(4'b1000, T_NONSEQ, 32'h1, 32'hA5A5_0002, 32'h33, 3'b111, 3'b000, 32'h0,          1'b0, 1'b1);
        vecs[10] = mk(4'b1000, T_IDLE,   32'h1, 32'hA5A5_0002, 32'h33, 3'b111, 3'b000, 32'h0,          1'b1, 1'b1);
        vecs[11] = mk(4'b0000, T_IDLE,   32'h1, 32'hA5A5_0002, 32'h33, 3'b000, 3'b111, 32'h0,          1'b1, 1'b0);
        vecs[12] = mk(4'b0000, T_IDLE,   32'h1, 32'hA5A5_0002, 32'h33, 3'b000, 3'b111, 32'h0,          1'b1, 1'b0);
        vecs[13] = mk(4'b1010, T_NONSEQ, 32'h1, 32'h22,        32'h33, 3'b111, 3'b000, 32'h0,          1'b1, 1'b0);
        vecs[14] = mk(4'b0000, T_IDLE,   32'h1, 32'h22,        32'h33, 3'b111, 3'b000, 32'h22,         1'b1, 1'b0);
        vecs[15] = mk(4'b0000, T_IDLE,   32'h1, 32'h22,        32'h33, 3'b111, 3'b000, 32'h0,          1'b1, 1'b0);

        HRESET = 1'b1;
        idle_inputs();
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Cycle-by-cycle table: inputs for the cycle, outputs observed at the falling edge
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i]);
            @(negedge HCLK);
            chk_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_ready, vecs[i].e_resp);
            next_cycle();
        end

        // Reset asserted in the middle of a default-subordinate ERROR
        idle_inputs();
        HSELd = 1'b1; HTRANS = T_NONSEQ;
        @(negedge HCLK);
        chk_out("rst_pre", 32'h0, 1'b1, 1'b0);
        next_cycle();
        @(negedge HCLK);
        chk_out("rst_err1", 32'h0, 1'b0, 1'b1);
        #1;
        HRESET = 1'b1;
        #1;
        chk_out("rst_async", 32'h0, 1'b1, 1'b0);
        next_cycle();
        idle_inputs();
        HRESET = 1'b0;
        @(negedge HCLK);
        chk_out("rst_after", 32'h0, 1'b1, 1'b0);
        next_cycle();
        HSEL1 = 1'b1; HTRANS = T_NONSEQ; HRDATA1 = 32'hCAFE_0001;
        @(negedge HCLK);
        chk_out("rst_addr", 32'h0, 1'b1, 1'b0);
        next_cycle();
        HSEL1 = 1'b0; HTRANS = T_IDLE;
        @(negedge HCLK);
        chk_out("rst_read", 32'hCAFE_0001, 1'b1, 1'b0);
        next_cycle();

        // Subordinate 1 never becomes ready
        idle_inputs();
        HSEL1 = 1'b1; HTRANS = T_NONSEQ; HRDATA1 = 32'hDEAD_0001;
        @(negedge HCLK);
        chk_out("to_addr", 32'h0, 1'b1, 1'b0);
        next_cycle();
        HSEL1 = 1'b0; HTRANS = T_IDLE; HREADYOUT1 = 1'b0;
`ifdef AHB_MUX_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            chk_out($sformatf("to_wait%0d", i), 32'hDEAD_0001, 1'b0, 1'b0);
            next_cycle();
        end
        @(negedge HCLK);
        chk_out("to_err1", 32'h0, 1'b0, 1'b1);
        next_cycle();
        HSEL2 = 1'b1; HTRANS = T_NONSEQ;
        @(negedge HCLK);
        chk_out("to_err2", 32'h0, 1'b1, 1'b1);
        next_cycle();
        HSEL2 = 1'b0; HTRANS = T_IDLE; HRDATA2 = 32'hBEEF_0002;
        @(negedge HCLK);
        chk_out("to_next", 32'hBEEF_0002, 1'b1, 1'b0);
        next_cycle();
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            chk({"stall", $sformatf("%0d", i), ".hready"}, {31'b0, HREADY}, 32'h0);
            next_cycle();
        end
        HREADYOUT1 = 1'b1;
        @(negedge HCLK);
        chk_out("stall_end", 32'hDEAD_0001, 1'b1, 1'b0);
        next_cycle();
        @(negedge HCLK);
        chk_out("stall_none", 32'h0, 1'b1, 1'b0);
        next_cycle();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
